io_port_bridge: RTL and testbench

IO_PORT_BRIDGE -- requirements
Module: io_port_bridge

---
 rtl/io_pkg.sv | 30 +++
 rtl/io_byte_fifo.sv | 63 ++++++
 rtl/io_port_bridge.sv | 160 ++++++++++++++++
 tb/tb_io_port_bridge.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// ---------------------------------------------------------------------------
// io_pkg -- shared constants and the address decoder for the IO port bridge.
//
// IO_ADDR_DATA : UART data register (write = TX byte, read = RX byte)
// IO_ADDR_CLK  : program-stop register on write, cycle-counter snapshot on
//                read (0x30004..0x30007, little-endian bytes)
// IO_HIT_SEL   : value of mem_a[17:16] that selects the IO window
// ---------------------------------------------------------------------------
package io_pkg;

  localparam logic [17:0] IO_ADDR_DATA = 18'h30000;
  localparam logic [17:0] IO_ADDR_CLK  = 18'h30004;
  localparam logic [1:0]  IO_HIT_SEL   = 2'b11;

  // Which IO register an in-window address refers to.
  typedef enum logic [1:0] {
    IO_REG_NONE,    // any other IO address: reads 0x00, writes ignored
    IO_REG_DATA,    // 0x30000
    IO_REG_CLK_LO,  // 0x30004: stop on write, snapshot load on read
    IO_REG_CLK_HI   // 0x30005..0x30007: upper snapshot bytes
  } io_reg_e;

  function automatic io_reg_e io_decode(input logic [17:0] addr);
    if (addr == IO_ADDR_DATA)              return IO_REG_DATA;
    if (addr == IO_ADDR_CLK)               return IO_REG_CLK_LO;
    if (addr[17:2] == IO_ADDR_CLK[17:2])   return IO_REG_CLK_HI;
    return IO_REG_NONE;
  endfunction

endpackage

// File: rtl/io_byte_fifo.sv
// ---------------------------------------------------------------------------
// io_byte_fifo -- synchronous byte FIFO with wrap-bit pointers.
//
// Ports:
//   clk_in, rst_in : clock, asynchronous active-low reset
//   push, push_data: write request and byte
//   pop            : read request (ignored when empty)
//   data           : current head byte (valid when !empty)
//   full, empty    : occupancy flags
//
// DEPTH must be a power of two and at least 2. A push while full succeeds
// when a pop happens in the same cycle, since the pop frees the slot.
// ---------------------------------------------------------------------------
module io_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                 (r_wr_ptr[AW] != r_rd_ptr[AW]);

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  assign data = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are meaningful, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk_in) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/io_port_bridge.sv
// ---------------------------------------------------------------------------
// io_port_bridge -- memory-mapped IO window for a CPU: UART TX/RX bytes,
// a free-running cycle counter with snapshot reads, and a program-stop flag.
//
// Ports:
//   clk_in, rst_in        : clock, asynchronous active-low reset
//   rdy_in                : CPU ready; bus requests ignored when low
//   mem_a, mem_wr,
//   mem_dout              : CPU address, write strobe, write byte
//   io_din, io_sel        : registered read data and its valid flag
//   tx_data, tx_valid,
//   tx_ready              : UART TX stream out of the byte FIFO
//   rx_data, rx_valid,
//   rx_ready              : UART RX handshake (rx_ready combinational)
//   program_stop          : sticky, set by a write to 0x30004
//   tx_overflow           : sticky, set when a TX byte is dropped
// ---------------------------------------------------------------------------
module io_port_bridge
  import io_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  io_din,
  output logic        io_sel,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_stop,
  output logic        tx_overflow
);

  logic             r_io_sel;
  logic [7:0]       r_io_din;
  logic             r_program_stop;
  logic             r_tx_overflow;
  logic             r_stop_pending;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_snap;

  logic             w_hit;
  io_reg_e          w_reg;
  logic             w_wr_data;
  logic             w_wr_stop;
  logic             w_rd_hit;
  logic             w_need_zero;
  logic             w_space;
  logic             w_push;
  logic [7:0]       w_push_data;
  logic             w_drop;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_byte_src;
  logic [7:0]       w_cnt_byte;
  logic [7:0]       w_rd_byte;
  logic             w_unused_addr;

  // Only mem_a[17:0] is decoded.
  assign w_unused_addr = ^mem_a[31:18];

  assign w_hit     = rdy_in && (mem_a[17:16] == IO_HIT_SEL);
  assign w_reg     = io_decode(mem_a[17:0]);
  assign w_wr_data = w_hit && mem_wr && (w_reg == IO_REG_DATA) && (mem_dout != 8'h00);
  assign w_wr_stop = w_hit && mem_wr && (w_reg == IO_REG_CLK_LO);
  assign w_rd_hit  = w_hit && !mem_wr;

  assign w_pop   = tx_valid && tx_ready;
  assign w_space = !w_full || w_pop;

  // The stop marker 0x00 owes a FIFO slot from the moment 0x30004 is written
  // until it is pushed; it outranks any data byte competing for the slot.
  assign w_need_zero = r_stop_pending || w_wr_stop;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    w_push      = 1'b0;
    w_push_data = mem_dout;
    w_drop      = 1'b0;
    if (w_need_zero) begin
      w_push      = w_space;
      w_push_data = 8'h00;
      w_drop      = w_wr_data;
    end else if (w_wr_data) begin
      w_push = w_space;
      w_drop = !w_space;
    end
  end

  io_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push     (w_push),
    .push_data(w_push_data),
    .pop      (w_pop),
    .data     (tx_data),
    .full     (w_full),
    .empty    (w_empty)
  );

  assign tx_valid = !w_empty;

  // A read of 0x30004 returns byte 0 of the live counter, the same value
  // being loaded into the snapshot; 0x30005..7 then read the snapshot.
  assign w_byte_src = (w_reg == IO_REG_CLK_LO) ? r_cnt : r_snap;
  assign w_cnt_byte = 8'(w_byte_src >> {mem_a[1:0], 3'b000});

  always_comb begin
    w_rd_byte = 8'h00;
    case (w_reg)
      IO_REG_DATA:   w_rd_byte = rx_valid ? rx_data : 8'h00;
      IO_REG_CLK_LO,
      IO_REG_CLK_HI: w_rd_byte = w_cnt_byte;
      default:       w_rd_byte = 8'h00;
    endcase
  end

  // Gated by rst_in so no RX byte is consumed while the bridge is in reset.
  assign rx_ready = rst_in && w_rd_hit && (w_reg == IO_REG_DATA) && rx_valid;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_io_sel       <= 1'b0;
      r_io_din       <= 8'h00;
      r_program_stop <= 1'b0;
      r_tx_overflow  <= 1'b0;
      r_stop_pending <= 1'b0;
      r_cnt          <= '0;
      r_snap         <= '0;
    end else begin
      r_io_sel       <= w_rd_hit;
      r_stop_pending <= w_need_zero && !w_space;
      if (w_rd_hit) r_io_din <= w_rd_byte;
      if (w_wr_stop) r_program_stop <= 1'b1;
      if (w_drop) r_tx_overflow <= 1'b1;
      // The counter stops at the stop-write edge itself, so it holds the
      // number of cycles that elapsed before the stop.
      if (!r_program_stop && !w_wr_stop) r_cnt <= r_cnt + CNT_W'(1);
      if (w_rd_hit && (w_reg == IO_REG_CLK_LO)) r_snap <= r_cnt;
    end
  end

  assign io_sel       = r_io_sel;
  assign io_din       = r_io_din;
  assign program_stop = r_program_stop;
  assign tx_overflow  = r_tx_overflow;

endmodule

// File: tb/tb_io_port_bridge.sv
// ---------------------------------------------------------------------------
// tb_io_port_bridge -- directed self-checking bench for io_port_bridge.
// Inputs change 1 ns after the rising edge; outputs are read at that point
// or later, and the TX stream is captured on the falling edge.
// ---------------------------------------------------------------------------
module tb_io_port_bridge;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  io_din;
  logic        io_sel;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_stop;
  logic        tx_overflow;

  int total = 0;
  int bad   = 0;

  logic [7:0] tx_q[$];

  io_port_bridge #(
    .FIFO_DEPTH(16),
    .CNT_W     (32)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .mem_a       (mem_a),
    .mem_wr      (mem_wr),
    .mem_dout    (mem_dout),
    .io_din      (io_din),
    .io_sel      (io_sel),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .program_stop(program_stop),
    .tx_overflow (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  // A byte is transferred at the next rising edge when valid && ready here.
  always @(negedge clk_in) begin
    if (rst_in && tx_valid && tx_ready) tx_q.push_back(tx_data);
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus_idle();
    rdy_in   = 1'b0;
    mem_a    = 32'h0;
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    rdy_in   = 1'b1;
    mem_a    = a;
    mem_wr   = 1'b1;
    mem_dout = d;
    step();
    bus_idle();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [7:0] d, output logic s);
    rdy_in = 1'b1;
    mem_a  = a;
    mem_wr = 1'b0;
    step();
    d = io_din;
    s = io_sel;
    bus_idle();
  endtask

  // Ends 1 ns after an edge with reset just released; the next edge is the
  // first one at which the counter increments (to 1).
  task automatic apply_reset();
    bus_idle();
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst_in   = 1'b0;
    repeat (3) step();
    rst_in = 1'b1;
    tx_q.delete();
  endtask

  task automatic test_reset();
    bus_idle();
    tx_ready = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    rst_in   = 1'b0;
    step();
    // RX read request presented while reset is held.
    rdy_in = 1'b1;
    mem_a  = 32'h0003_0000;
    mem_wr = 1'b0;
    #1;
    total++;
    if (rx_ready !== 1'b0) begin bad++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
    step();
    total++;
    if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    total++;
    if (io_sel !== 1'b0) begin bad++; $display("FAIL reset_io_sel: got %b want 0", io_sel); end
    total++;
    if (program_stop !== 1'b0 || tx_overflow !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got stop=%b ovf=%b want 0 0", program_stop, tx_overflow);
    end
    bus_idle();
  endtask

  task automatic test_tx_basic();
    apply_reset();
    tx_ready = 1'b1;
    bus_write(32'h0003_0000, 8'h41);
    bus_write(32'h0003_0000, 8'h00);
    bus_write(32'h0003_0000, 8'h42);
    repeat (4) step();
    total++;
    if (tx_q.size() !== 2) begin
      bad++; $display("FAIL tx_basic_count: got %0d want 2", tx_q.size());
    end else begin
      total++;
      if (tx_q[0] !== 8'h41 || tx_q[1] !== 8'h42) begin
        bad++; $display("FAIL tx_basic_bytes: got %h %h want 41 42", tx_q[0], tx_q[1]);
      end
    end
    total++;
    if (tx_overflow !== 1'b0) begin bad++; $display("FAIL tx_basic_ovf: got %b want 0", tx_overflow); end
  endtask

  task automatic test_overflow();
    // Part 1: 17 writes with the sink stalled; the 17th byte is dropped.
    apply_reset();
    for (int i = 0; i < 16; i++) bus_write(32'h0003_0000, 8'(i + 1));
    total++;
    if (tx_overflow !== 1'b0) begin bad++; $display("FAIL ovf_after16: got %b want 0", tx_overflow); end
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
      bad++; $display("FAIL ovf_head: got valid=%b data=%h want 1 01", tx_valid, tx_data);
    end
    bus_write(32'h0003_0000, 8'h11);
    total++;
    if (tx_overflow !== 1'b1) begin bad++; $display("FAIL ovf_after17: got %b want 1", tx_overflow); end
    tx_ready = 1'b1;
    repeat (20) step();
    total++;
    if (tx_q.size() !== 16) begin
      bad++; $display("FAIL ovf_drain_count: got %0d want 16", tx_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        total++;
        if (tx_q[i] !== 8'(i + 1)) begin
          bad++; $display("FAIL ovf_drain_byte%0d: got %h want %h", i, tx_q[i], 8'(i + 1));
        end
      end
    end
    total++;
    if (tx_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", tx_overflow); end

    // Part 2: same fill, but the sink pops on the 17th write's edge.
    apply_reset();
    total++;
    if (tx_overflow !== 1'b0) begin bad++; $display("FAIL ovf_reset_clear: got %b want 0", tx_overflow); end
    for (int i = 0; i < 16; i++) bus_write(32'h0003_0000, 8'(i + 1));
    tx_ready = 1'b1;
    bus_write(32'h0003_0000, 8'h11);
    tx_ready = 1'b0;
    total++;
    if (tx_overflow !== 1'b0) begin bad++; $display("FAIL ovf_pop_push: got %b want 0", tx_overflow); end
    tx_ready = 1'b1;
    repeat (20) step();
    total++;
    if (tx_q.size() !== 17) begin
      bad++; $display("FAIL ovf_pop_drain_count: got %0d want 17", tx_q.size());
    end else begin
      for (int i = 0; i < 17; i++) begin
        total++;
        if (tx_q[i] !== 8'(i + 1)) begin
          bad++; $display("FAIL ovf_pop_byte%0d: got %h want %h", i, tx_q[i], 8'(i + 1));
        end
      end
    end
  endtask

  task automatic test_rx();
    logic [7:0] d;
    logic       s;
    apply_reset();
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    rdy_in   = 1'b1;
    mem_a    = 32'h0003_0000;
    mem_wr   = 1'b0;
    #1;
    total++;
    if (rx_ready !== 1'b1) begin bad++; $display("FAIL rx_ready_pulse: got %b want 1", rx_ready); end
    step();
    bus_idle();
    #1;
    total++;
    if (rx_ready !== 1'b0) begin bad++; $display("FAIL rx_ready_after: got %b want 0", rx_ready); end
    total++;
    if (io_sel !== 1'b1 || io_din !== 8'h5A) begin
      bad++; $display("FAIL rx_read_data: got sel=%b din=%h want 1 5a", io_sel, io_din);
    end
    step();
    total++;
    if (io_sel !== 1'b0) begin bad++; $display("FAIL rx_sel_drop: got %b want 0", io_sel); end

    // Request with rdy_in low is ignored.
    rdy_in = 1'b0;
    mem_a  = 32'h0003_0000;
    #1;
    total++;
    if (rx_ready !== 1'b0) begin bad++; $display("FAIL rx_rdy_low: got %b want 0", rx_ready); end
    step();
    total++;
    if (io_sel !== 1'b0) begin bad++; $display("FAIL rx_rdy_low_sel: got %b want 0", io_sel); end

    rx_valid = 1'b0;
    rdy_in   = 1'b1;
    mem_a    = 32'h0003_0000;
    #1;
    total++;
    if (rx_ready !== 1'b0) begin bad++; $display("FAIL rx_empty_ready: got %b want 0", rx_ready); end
    step();
    bus_idle();
    total++;
    if (io_sel !== 1'b1 || io_din !== 8'h00) begin
      bad++; $display("FAIL rx_empty_data: got sel=%b din=%h want 1 00", io_sel, io_din);
    end

    // Other IO address reads 0x00; non-IO address gives no io_sel.
    rx_valid = 1'b1;
    bus_read(32'h0003_0000, d, s);
    bus_read(32'h0003_0010, d, s);
    total++;
    if (s !== 1'b1 || d !== 8'h00) begin
      bad++; $display("FAIL rx_other_io: got sel=%b din=%h want 1 00", s, d);
    end
    bus_read(32'h0002_0000, d, s);
    total++;
    if (s !== 1'b0) begin bad++; $display("FAIL rx_non_io: got sel=%b want 0", s); end
    rx_valid = 1'b0;
  endtask

  task automatic test_counter();
    logic [7:0] d;
    logic       s;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h34; exp_b[1] = 8'h12; exp_b[2] = 8'h00; exp_b[3] = 8'h00;
    apply_reset();
    repeat (32'h1234) step();
    // The 0x30004 read lands on edge 0x1235, seeing the counter at 0x1234.
    for (int i = 0; i < 4; i++) begin
      bus_read(32'h0003_0004 + 32'(i), d, s);
      total++;
      if (s !== 1'b1 || d !== exp_b[i]) begin
        bad++; $display("FAIL cnt_byte%0d: got sel=%b din=%h want 1 %h", i, s, d, exp_b[i]);
      end
    end
    // Fresh snapshot on edge 0x1239 sees 0x1238.
    bus_read(32'h0003_0004, d, s);
    total++;
    if (d !== 8'h38) begin bad++; $display("FAIL cnt_resnap: got %h want 38", d); end
  endtask

  task automatic test_stop_full();
    logic [7:0] d;
    logic       s;
    apply_reset();
    for (int i = 0; i < 16; i++) bus_write(32'h0003_0000, 8'(8'h21 + i));
    total++;
    if (program_stop !== 1'b0) begin bad++; $display("FAIL stop_pre: got %b want 0", program_stop); end
    // Stop write on edge 17; counter holds 16 from then on.
    bus_write(32'h0003_0004, 8'hFF);
    total++;
    if (program_stop !== 1'b1) begin bad++; $display("FAIL stop_set: got %b want 1", program_stop); end
    repeat (3) step();
    bus_read(32'h0003_0004, d, s);
    total++;
    if (d !== 8'h10) begin bad++; $display("FAIL stop_cnt_frozen: got %h want 10", d); end
    tx_ready = 1'b1;
    repeat (25) step();
    total++;
    if (tx_q.size() !== 17) begin
      bad++; $display("FAIL stop_drain_count: got %0d want 17", tx_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        total++;
        if (tx_q[i] !== 8'(8'h21 + i)) begin
          bad++; $display("FAIL stop_byte%0d: got %h want %h", i, tx_q[i], 8'(8'h21 + i));
        end
      end
      total++;
      if (tx_q[16] !== 8'h00) begin bad++; $display("FAIL stop_marker: got %h want 00", tx_q[16]); end
    end
    total++;
    if (tx_overflow !== 1'b0) begin bad++; $display("FAIL stop_no_drop: got %b want 0", tx_overflow); end
  endtask

  task automatic test_rdy_and_reset();
    logic [7:0] d;
    logic       s;
    apply_reset();
    rdy_in   = 1'b0;
    mem_a    = 32'h0003_0000;
    mem_wr   = 1'b1;
    mem_dout = 8'h55;
    step();
    bus_idle();
    total++;
    if (tx_valid !== 1'b0) begin bad++; $display("FAIL rdy_low_push: got %b want 0", tx_valid); end
    for (int i = 0; i < 5; i++) bus_write(32'h0003_0000, 8'(8'h61 + i));
    bus_write(32'h0003_0004, 8'h01);
    bus_read(32'h0003_0010, d, s);
    total++;
    if (tx_valid !== 1'b1 || program_stop !== 1'b1 || s !== 1'b1) begin
      bad++; $display("FAIL midreset_pre: got valid=%b stop=%b sel=%b want 1 1 1", tx_valid, program_stop, s);
    end
    rst_in = 1'b0;
    #1;
    total++;
    if (tx_valid !== 1'b0) begin bad++; $display("FAIL midreset_tx_valid: got %b want 0", tx_valid); end
    total++;
    if (program_stop !== 1'b0 || tx_overflow !== 1'b0 || io_sel !== 1'b0) begin
      bad++; $display("FAIL midreset_flags: got stop=%b ovf=%b sel=%b want 0 0 0", program_stop, tx_overflow, io_sel);
    end
    repeat (2) step();
    rst_in = 1'b1;
    tx_q.delete();
    tx_ready = 1'b1;
    repeat (10) step();
    total++;
    if (tx_q.size() !== 0 || tx_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_residue: got count=%0d valid=%b want 0 0", tx_q.size(), tx_valid);
    end
  endtask

  initial begin
    rst_in   = 1'b0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    bus_idle();
    test_reset();
    test_tx_basic();
    test_overflow();
    test_rx();
    test_counter();
    test_stop_full();
    test_rdy_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
